// File: rtl/point_mul_fixed_window_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : elliptic_curve_structs (package)                             |
// | Description : Shared curve types, the point identity, the window-walker    |
// |               state encoding and the coordinate arithmetic used by the     |
// |               add/double sub-units.                                        |
// | Revision    : 1.0 - fixed-window multiplier support added                  |
// +----------------------------------------------------------------------------+
package elliptic_curve_structs;

   localparam int SCALAR_WIDTH = 16;
   localparam int WINDOW_WIDTH = 4;
   localparam int COORD_W      = 16;

   // Field modulus of the reference curve group (largest 16-bit prime).
   localparam logic [COORD_W-1:0] FIELD_P = 16'd65521;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } curve_point_t;

   // Group identity; adding it to any point leaves that point unchanged.
   localparam curve_point_t inf_point = '0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      SCAN = 3'd2,
      NEXT = 3'd3,
      DBL  = 3'd4,
      ADD  = 3'd5,
      FIN  = 3'd6
   } pmw_state_t;

   // Modular add of two reduced coordinates; one conditional subtract suffices.
   function automatic logic [COORD_W-1:0] coord_add(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      logic [COORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, FIELD_P}) begin
         s = s - {1'b0, FIELD_P};
      end
      return s[COORD_W-1:0];
   endfunction

   function automatic curve_point_t pt_add(input curve_point_t a, input curve_point_t b);
      curve_point_t r;
      r.x = coord_add(a.x, b.x);
      r.y = coord_add(a.y, b.y);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/point_mul_fixed_window_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : point_mul_fixed_window_if                                    |
// | Description : start/busy/done request bus carrying base point, scalar and  |
// |               result of one scalar multiplication.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface point_mul_fixed_window_if
   import elliptic_curve_structs::*;
#(
   parameter int SCALAR_W = SCALAR_WIDTH
);
   logic                start;
   curve_point_t        P;
   logic [SCALAR_W-1:0] k;
   logic                busy;
   logic                done;
   curve_point_t        R;

   modport master (output start, output P, output k,
                   input  busy,  input  done, input R);

   modport slave  (input  start, input  P, input  k,
                   output busy,  output done, output R);
endinterface
`default_nettype wire

// File: rtl/point_mul_fixed_window_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : point_mul_table                                              |
// | Description : 2^WIN_W entry table of precomputed multiples of the base     |
// |               point. One synchronous write port, one combinational read.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module point_mul_table
   import elliptic_curve_structs::*;
#(
   parameter int WIN_W = WINDOW_WIDTH
)(
   input  logic             clk,
   input  logic             Reset,
   input  logic             we,
   input  logic [WIN_W-1:0] waddr,
   input  curve_point_t     wdata,
   input  logic [WIN_W-1:0] raddr,
   output curve_point_t     rdata
);
   localparam int c_depth = 2 ** WIN_W;

   curve_point_t w_entry [c_depth];

   genvar gi;
   generate
      for (gi = 0; gi < c_depth; gi++) begin : g_entry
         curve_point_t r_val;

         // Entry register: cleared to the identity, loaded when addressed
         always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
               r_val <= inf_point;
            end else if (we && (waddr == WIN_W'(gi))) begin
               r_val <= wdata;
            end
         end

         assign w_entry[gi] = r_val;
      end
   endgenerate

   assign rdata = w_entry[raddr];
endmodule
`default_nettype wire

// File: rtl/point_mul_fixed_window_units.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : PointAddAdapter / point_double                               |
// | Description : Multi-cycle point adder and doubler. Each is restarted by a  |
// |               pulse on Reset and raises Done as a level once the result is |
// |               valid; Done stays high until the next Reset.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module PointAddAdapter
   import elliptic_curve_structs::*;
(
   input  logic         clk,
   input  logic         Reset,
   input  curve_point_t A,
   input  curve_point_t B,
   output curve_point_t Sum,
   output logic         Done
);
   localparam logic [1:0] c_last_cnt = 2'd1;

   logic [1:0]   r_cnt;
   curve_point_t r_sum;
   logic         r_done;

   // Wait out the adder latency, then present the sum and hold Done
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_cnt  <= '0;
         r_sum  <= inf_point;
         r_done <= 1'b0;
      end else if (!r_done) begin
         if (r_cnt == c_last_cnt) begin
            r_sum  <= pt_add(A, B);
            r_done <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 2'd1;
         end
      end
   end

   assign Sum  = r_sum;
   assign Done = r_done;
endmodule

module point_double
   import elliptic_curve_structs::*;
(
   input  logic         clk,
   input  logic         Reset,
   input  curve_point_t A,
   output curve_point_t Result,
   output logic         Done
);
   curve_point_t r_res;
   logic         r_done;

   // Single-cycle doubling after release from reset; result held with Done
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_res  <= inf_point;
         r_done <= 1'b0;
      end else if (!r_done) begin
         r_res  <= pt_add(A, A);
         r_done <= 1'b1;
      end
   end

   assign Result = r_res;
   assign Done   = r_done;
endmodule
`default_nettype wire

// File: rtl/point_mul_fixed_window.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : point_mul_fixed_window                                       |
// | Description : R = k*P by MSB-first fixed-window scalar multiplication.     |
// |               Builds a table of 0..2^WIN_W-1 multiples of P, skips leading |
// |               zero windows, then doubles WIN_W times and adds one table    |
// |               entry per window. One shared adder and one doubler.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module point_mul_fixed_window
   import elliptic_curve_structs::*;
#(
   parameter int SCALAR_W = SCALAR_WIDTH,
   parameter int WIN_W    = WINDOW_WIDTH
)(
   input  logic                      clk,
   input  logic                      Reset,
   point_mul_fixed_window_if.slave   bus
);
   localparam int c_nwin   = (SCALAR_W + WIN_W - 1) / WIN_W;
   localparam int c_kpad_w = c_nwin * WIN_W;
   localparam int c_jw     = (c_nwin > 1) ? $clog2(c_nwin) : 1;
   localparam int c_dw     = $clog2(WIN_W + 1);
   localparam int c_depth  = 2 ** WIN_W;

   localparam logic [c_jw-1:0]  c_j_top    = c_jw'(c_nwin - 1);
   localparam logic [WIN_W-1:0] c_pidx_top = WIN_W'(c_depth - 1);

   // Sub-unit handshake phases: pulse the unit reset, hold one cycle, wait for Done
   localparam logic [1:0] c_ph_issue = 2'd0;
   localparam logic [1:0] c_ph_hold  = 2'd1;
   localparam logic [1:0] c_ph_wait  = 2'd2;

   pmw_state_t          r_state, w_state_nxt;
   curve_point_t        r_pq, w_pq_nxt;
   curve_point_t        r_racc, w_racc_nxt;
   curve_point_t        r_res, w_res_nxt;
   logic [c_kpad_w-1:0] r_kq, w_kq_nxt;
   logic [c_kpad_w-1:0] w_kshift;
   logic [c_jw-1:0]     r_j, w_j_nxt;
   logic [c_dw-1:0]     r_dcnt, w_dcnt_nxt;
   logic [WIN_W-1:0]    r_pidx, w_pidx_nxt;
   logic [WIN_W-1:0]    w_digit;
   logic [1:0]          r_phase, w_phase_nxt;
   logic                r_add_rst, w_add_rst_nxt;
   logic                r_dbl_rst, w_dbl_rst_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;

   logic                w_tbl_we;
   logic [WIN_W-1:0]    w_tbl_waddr;
   curve_point_t        w_tbl_wdata;
   logic [WIN_W-1:0]    w_tbl_raddr;
   curve_point_t        w_tbl_rdata;

   curve_point_t        w_add_b;
   curve_point_t        w_add_sum;
   logic                w_add_done;
   curve_point_t        w_dbl_res;
   logic                w_dbl_done;
   logic                w_add_unit_rst;
   logic                w_dbl_unit_rst;

   // Current window digit, counted from the LSB end of the zero-padded scalar
   assign w_kshift = r_kq >> (r_j * WIN_W);
   assign w_digit  = w_kshift[WIN_W-1:0];

   // Table precompute reads the previous entry; SCAN/ADD read the digit's entry
   assign w_tbl_raddr = (r_state == PRE) ? (r_pidx - WIN_W'(1)) : w_digit;
   // The adder extends the table by Pq during PRE and accumulates otherwise
   assign w_add_b     = (r_state == PRE) ? r_pq : r_racc;

   assign w_add_unit_rst = Reset | r_add_rst;
   assign w_dbl_unit_rst = Reset | r_dbl_rst;

   point_mul_table #(
      .WIN_W (WIN_W)
   ) u_table (
      .clk   (clk),
      .Reset (Reset),
      .we    (w_tbl_we),
      .waddr (w_tbl_waddr),
      .wdata (w_tbl_wdata),
      .raddr (w_tbl_raddr),
      .rdata (w_tbl_rdata)
   );

   PointAddAdapter u_add (
      .clk   (clk),
      .Reset (w_add_unit_rst),
      .A     (w_tbl_rdata),
      .B     (w_add_b),
      .Sum   (w_add_sum),
      .Done  (w_add_done)
   );

   point_double u_dbl (
      .clk    (clk),
      .Reset  (w_dbl_unit_rst),
      .A      (r_racc),
      .Result (w_dbl_res),
      .Done   (w_dbl_done)
   );

   // Next-state and datapath next values for the window walker
   always_comb begin
      w_state_nxt   = r_state;
      w_pq_nxt      = r_pq;
      w_kq_nxt      = r_kq;
      w_racc_nxt    = r_racc;
      w_res_nxt     = r_res;
      w_j_nxt       = r_j;
      w_dcnt_nxt    = r_dcnt;
      w_pidx_nxt    = r_pidx;
      w_phase_nxt   = r_phase;
      w_add_rst_nxt = 1'b0;
      w_dbl_rst_nxt = 1'b0;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_tbl_we      = 1'b0;
      w_tbl_waddr   = '0;
      w_tbl_wdata   = inf_point;

      case (r_state)
         IDLE: begin
            if (!r_busy) begin
               // Accept: latch operands; T[0] is the identity for every request
               if (bus.start) begin
                  w_pq_nxt    = bus.P;
                  w_kq_nxt    = c_kpad_w'(bus.k);
                  w_busy_nxt  = 1'b1;
                  w_tbl_we    = 1'b1;
                  w_tbl_waddr = '0;
                  w_tbl_wdata = inf_point;
               end
            end else if (r_kq == '0) begin
               w_res_nxt  = inf_point;
               w_done_nxt = 1'b1;
               w_busy_nxt = 1'b0;
            end else begin
               w_tbl_we    = 1'b1;
               w_tbl_waddr = WIN_W'(1);
               w_tbl_wdata = r_pq;
               w_racc_nxt  = inf_point;
               w_phase_nxt = c_ph_issue;
               if (WIN_W == 1) begin
                  w_state_nxt = SCAN;
                  w_j_nxt     = c_j_top;
               end else begin
                  w_state_nxt = PRE;
                  w_pidx_nxt  = WIN_W'(2);
               end
            end
         end

         PRE: begin
            case (r_phase)
               c_ph_issue: begin
                  w_add_rst_nxt = 1'b1;
                  w_phase_nxt   = c_ph_hold;
               end
               c_ph_hold: w_phase_nxt = c_ph_wait;
               default: begin
                  if (w_add_done) begin
                     w_tbl_we    = 1'b1;
                     w_tbl_waddr = r_pidx;
                     w_tbl_wdata = w_add_sum;
                     w_phase_nxt = c_ph_issue;
                     if (r_pidx == c_pidx_top) begin
                        w_state_nxt = SCAN;
                        w_j_nxt     = c_j_top;
                     end else begin
                        w_pidx_nxt = r_pidx + WIN_W'(1);
                     end
                  end
               end
            endcase
         end

         SCAN: begin
            // Racc is still the identity here, so a zero digit contributes nothing
            if (w_digit == '0) begin
               w_j_nxt = r_j - c_jw'(1);
            end else begin
               w_racc_nxt  = w_tbl_rdata;
               w_state_nxt = NEXT;
            end
         end

         NEXT: begin
            if (r_j == '0) begin
               w_state_nxt = FIN;
            end else begin
               w_j_nxt     = r_j - c_jw'(1);
               w_dcnt_nxt  = c_dw'(WIN_W);
               w_phase_nxt = c_ph_issue;
               w_state_nxt = DBL;
            end
         end

         DBL: begin
            case (r_phase)
               c_ph_issue: begin
                  w_dbl_rst_nxt = 1'b1;
                  w_phase_nxt   = c_ph_hold;
               end
               c_ph_hold: w_phase_nxt = c_ph_wait;
               default: begin
                  if (w_dbl_done) begin
                     w_racc_nxt  = w_dbl_res;
                     w_dcnt_nxt  = r_dcnt - c_dw'(1);
                     w_phase_nxt = c_ph_issue;
                     if (r_dcnt == c_dw'(1)) begin
                        w_state_nxt = (w_digit != '0) ? ADD : NEXT;
                     end
                  end
               end
            endcase
         end

         ADD: begin
            case (r_phase)
               c_ph_issue: begin
                  w_add_rst_nxt = 1'b1;
                  w_phase_nxt   = c_ph_hold;
               end
               c_ph_hold: w_phase_nxt = c_ph_wait;
               default: begin
                  if (w_add_done) begin
                     w_racc_nxt  = w_add_sum;
                     w_phase_nxt = c_ph_issue;
                     w_state_nxt = NEXT;
                  end
               end
            endcase
         end

         FIN: begin
            w_res_nxt   = r_racc;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath, handshake and sub-unit reset-pulse registers
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_pq      <= inf_point;
         r_kq      <= '0;
         r_racc    <= inf_point;
         r_res     <= inf_point;
         r_j       <= '0;
         r_dcnt    <= '0;
         r_pidx    <= '0;
         r_phase   <= c_ph_issue;
         r_add_rst <= 1'b0;
         r_dbl_rst <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_pq      <= w_pq_nxt;
         r_kq      <= w_kq_nxt;
         r_racc    <= w_racc_nxt;
         r_res     <= w_res_nxt;
         r_j       <= w_j_nxt;
         r_dcnt    <= w_dcnt_nxt;
         r_pidx    <= w_pidx_nxt;
         r_phase   <= w_phase_nxt;
         r_add_rst <= w_add_rst_nxt;
         r_dbl_rst <= w_dbl_rst_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.R    = r_res;
endmodule
`default_nettype wire
